dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Data-memory responder for the core datapath: the memory-side end of the mem_rd/mem_wr interface driven by the control unit.
- Accepts word loads and stores, holds them for a parameterized access latency, and performs them on an internal word array.
- Stalls the core while an access is outstanding, then returns load data.
- Replaces the zero-latency data memory so the core can run with realistic multi-cycle memories.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array (power of two).
- LATENCY, 2, BUSY-state cycles per access (>=1).

Ports:
- clk  in  1  clock.
- rst  in  1  reset, asynchronous, active-low.
- mem_rd  in  1  load request, held by the core while stall is high.
- mem_wr  in  1  store request, held by the core while stall is high.
- addr  in  32  byte address from the ALU.
- wdata  in  32  store data (word_t).
- rdata  out  32  load data (word_t), registered.
- rdata_valid  out  1  one-cycle pulse, high in DONE after a good load.
- stall  out  1  core hold request.
- misalign_err  out  1  one-cycle pulse in DONE for an illegal request.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - rst is asynchronous, active-low.
  - While rst is low: state=IDLE, counter=0, rdata=0, rdata_valid=0, misalign_err=0, and stall is forced to 0.
  - Array contents are not reset.
- States: IDLE, BUSY, DONE (dmem_state_t).
- IDLE:
  - A request is mem_rd|mem_wr.
  - On a legal request: latch op, word index and wdata; load counter=LATENCY-1; go to BUSY.
  - On an illegal request: go directly to DONE with the error flagged. Illegal means addr[1:0]!=0, or mem_rd and mem_wr both high.
- BUSY:
  - Counter decrements each cycle.
  - When counter==0, the access is performed on the clock edge and the state goes to DONE.
  - Store: the latched wdata is written to the latched index.
  - Load: the array word is registered into rdata.
- DONE:
  - Lasts exactly one cycle, then IDLE.
  - Load: rdata_valid=1.
  - Illegal request: misalign_err=1, rdata=0, no array access.
  - Store: both flags 0.
- stall is combinational:
  - 1 when (state==IDLE and request) or state==BUSY.
  - 0 in DONE, so the core retires the instruction on the edge ending DONE.
- Timing:
  - Legal request presented at cycle t: stall high at t..t+LATENCY, rdata_valid high at t+LATENCY+1.
  - Total occupancy is LATENCY+2 cycles including DONE.
  - Illegal request at t: stall high at t only, misalign_err high at t+1.
- Word index is addr[log2(DEPTH)+1:2]. Higher address bits are ignored, so addresses wrap modulo DEPTH words.
- Requests are latched in IDLE only:
  - Changes to addr, wdata, mem_rd or mem_wr during BUSY are ignored.
  - Deasserting the request mid-BUSY does not cancel the access.
- In DONE, a request present in the same cycle is ignored. The next request is sampled in the following IDLE cycle, so back-to-back accesses have no overlap.
- Reset mid-BUSY aborts the access: no write occurs and rdata stays 0.
- rdata holds its last value until the next load or illegal completion.

Optional Feature:
- Macro: DMEM_BYTE_STROBE_EN.
- Defined:
  - Adds input port wstrb[3:0], latched with wdata.
  - A store writes only the bytes whose strobe is 1; wstrb=0 is a legal no-op store.
- Undefined:
  - No wstrb port.
  - Every store writes the full word.

Decomposition:
- Shared package RISCV_pkg:
  - dmem_state_t enum {IDLE, BUSY, DONE}.
  - DMEM_DEPTH_DEF and DMEM_LATENCY_DEF constants.
  - Reuse the existing word_t.
- Sub-module dmem_array:
  - Single-port synchronous word RAM: clk, we, idx, wdata, rdata, plus optional byte enables.
  - No reset.
  - Keeps storage separate from the FSM.

Test Plan:
1. Store then load, LATENCY=2:
   - mem_wr, addr=0x10, wdata=0xDEADBEEF; then mem_rd at addr=0x10.
   - Each access has stall high for 3 cycles.
   - The load gives rdata=0xDEADBEEF with rdata_valid on the 4th cycle.
2. Misaligned load at addr=0x13:
   - stall high for 1 cycle, then misalign_err=1 and rdata=0.
   - The array is unchanged; reading 0x10 afterwards gives the old value.
3. Illegal dual request, mem_rd=mem_wr=1 at 0x20:
   - misalign_err pulse, no write.
   - A subsequent load at 0x20 returns the prior contents.
4. Wrap-around with DEPTH=1024:
   - Store 0x12345678 at addr=0x1000 (index wraps to 0).
   - A load at addr=0x0 returns 0x12345678.
5. Reset during BUSY:
   - Store issued; rst=0 during the second BUSY cycle.
   - All outputs go to 0 immediately.
   - A load from the same address after reset returns the old data.
6. With DMEM_BYTE_STROBE_EN defined:
   - Word at 0x40 = 0xAABBCCDD; store wdata=0x11223344 with wstrb=4'b0101.
   - A load at 0x40 returns 0xAA22CC44.

Source files
------------

// File: rtl/dmem_responder_pkg.sv
// Shared core types: word type, data-memory responder states and default sizing.
package RISCV_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } dmem_state_t;

    localparam int unsigned DMEM_DEPTH_DEF   = 1024;
    localparam int unsigned DMEM_LATENCY_DEF = 2;

    // A request is rejected when it is not word aligned or asks for a load and a store at once.
    function automatic logic dmem_req_illegal(input logic rd, input logic wr, input logic [1:0] addr_lo);
        return (addr_lo != 2'b00) || (rd && wr);
    endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Single-port word RAM for the data-memory responder: synchronous byte-enabled write,
// asynchronous read of the addressed word. Contents are never reset.
module dmem_array
    import RISCV_pkg::*;
#(
    parameter int unsigned DEPTH = DMEM_DEPTH_DEF,
    parameter int unsigned IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  word_t            wdata,
    output word_t            rdata
);

    word_t mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder for the core's mem_rd/mem_wr interface.
// Optional per-byte store strobes are enabled with `define DMEM_BYTE_STROBE_EN.
module dmem_responder
    import RISCV_pkg::*;
#(
    parameter int unsigned DEPTH   = DMEM_DEPTH_DEF,
    parameter int unsigned LATENCY = DMEM_LATENCY_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] addr,
    input  word_t       wdata,
`ifdef DMEM_BYTE_STROBE_EN
    input  logic [3:0]  wstrb,
`endif
    output word_t       rdata,
    output logic        rdata_valid,
    output logic        stall,
    output logic        misalign_err
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(LATENCY + 1);

    dmem_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic             op_rd_q;
    logic [IDX_W-1:0] idx_q;
    word_t            wdata_q;
    logic [3:0]       be_q;
    word_t            arr_rdata;
    logic             req;
    logic             illegal;
    logic             access_now;
    logic             arr_we;

    // Address bits above the word index are deliberately ignored so accesses wrap.
    logic unused_addr_hi;
    assign unused_addr_hi = ^addr[31:IDX_W+2];

    assign req     = mem_rd | mem_wr;
    assign illegal = dmem_req_illegal(mem_rd, mem_wr, addr[1:0]);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        access_now = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = illegal ? DONE : BUSY;
                end
            end
            BUSY: begin
                if (cnt_q == '0) begin
                    access_now = 1'b1;
                    state_d    = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // Gated by rst so a request held during reset cannot raise stall.
        stall  = rst && ((state_q == IDLE && req) || state_q == BUSY);
        arr_we = access_now && !op_rd_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q        <= '0;
            op_rd_q      <= 1'b0;
            idx_q        <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            rdata        <= '0;
            rdata_valid  <= 1'b0;
            misalign_err <= 1'b0;
        end else begin
            rdata_valid  <= 1'b0;
            misalign_err <= 1'b0;
            if (state_q == IDLE && req) begin
                if (illegal) begin
                    misalign_err <= 1'b1;
                    rdata        <= '0;
                end else begin
                    cnt_q   <= CNT_W'(LATENCY - 1);
                    op_rd_q <= mem_rd;
                    idx_q   <= addr[IDX_W+1:2];
                    wdata_q <= wdata;
`ifdef DMEM_BYTE_STROBE_EN
                    be_q    <= wstrb;
`else
                    be_q    <= '1;
`endif
                end
            end else if (state_q == BUSY) begin
                if (access_now) begin
                    if (op_rd_q) begin
                        rdata       <= arr_rdata;
                        rdata_valid <= 1'b1;
                    end
                end else begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end
        end
    end

    dmem_array #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .be    (be_q),
        .idx   (idx_q),
        .wdata (wdata_q),
        .rdata (arr_rdata)
    );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH=1024, LATENCY=2): vector table plus corner sequences.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        stall;
    logic        misalign_err;

    int unsigned checks = 0;
    int unsigned errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(
        .DEPTH   (1024),
        .LATENCY (2)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mem_rd       (mem_rd),
        .mem_wr       (mem_wr),
        .addr         (addr),
        .wdata        (wdata),
`ifdef DMEM_BYTE_STROBE_EN
        .wstrb        (wstrb),
`endif
        .rdata        (rdata),
        .rdata_valid  (rdata_valid),
        .stall        (stall),
        .misalign_err (misalign_err)
    );

    typedef struct {
        logic        rd;
        logic        wr;
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  s;
        int unsigned exp_stall;
        logic        exp_valid;
        logic        exp_err;
        logic [31:0] exp_rdata;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Presents one request at a falling edge, holds it while stall is high, returns DONE-cycle outputs.
    task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] s, output int unsigned n, output logic v, output logic e,
                          output logic [31:0] q, output logic early);
        @(negedge clk);
        mem_rd = rd; mem_wr = wr; addr = a; wdata = d; wstrb = s;
        n = 0; early = 1'b0;
        #1;
        while (stall && n < 20) begin
            if (rdata_valid || misalign_err) early = 1'b1;
            n++;
            @(negedge clk);
            #1;
        end
        v = rdata_valid; e = misalign_err; q = rdata;
        mem_rd = 1'b0; mem_wr = 1'b0;
    endtask

    vec_t        vecs [$];
    int unsigned n;
    logic        v, e, early;
    logic [31:0] q;
    logic [7:0]  pat_stall, pat_valid;

    initial begin
        rst = 1'b0; mem_rd = 1'b1; mem_wr = 1'b0; addr = 32'h10; wdata = '0; wstrb = 4'hF;

        // Reset state with a request held: stall must stay low.
        #12;
        check("reset_stall", {31'b0, stall}, 32'd0);
        check("reset_rdata", rdata, 32'd0);
        check("reset_flags", {30'b0, rdata_valid, misalign_err}, 32'd0);
        mem_rd = 1'b0;
        @(negedge clk);
        rst = 1'b1;

        vecs = '{
            '{1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 4'hF, 3, 1'b0, 1'b0, 32'h0000_0000},
            '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 3, 1'b1, 1'b0, 32'hDEAD_BEEF},
            '{1'b1, 1'b0, 32'h0000_0013, 32'h0,         4'hF, 1, 1'b0, 1'b1, 32'h0000_0000},
            '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 3, 1'b1, 1'b0, 32'hDEAD_BEEF},
            '{1'b0, 1'b1, 32'h0000_0020, 32'h0BAD_F00D, 4'hF, 3, 1'b0, 1'b0, 32'hDEAD_BEEF},
            '{1'b1, 1'b1, 32'h0000_0020, 32'hFFFF_FFFF, 4'hF, 1, 1'b0, 1'b1, 32'h0000_0000},
            '{1'b1, 1'b0, 32'h0000_0020, 32'h0,         4'hF, 3, 1'b1, 1'b0, 32'h0BAD_F00D},
            '{1'b0, 1'b1, 32'h0000_1000, 32'h1234_5678, 4'hF, 3, 1'b0, 1'b0, 32'h0BAD_F00D},
            '{1'b1, 1'b0, 32'h0000_0000, 32'h0,         4'hF, 3, 1'b1, 1'b0, 32'h1234_5678},
            '{1'b0, 1'b1, 32'h0000_0012, 32'h7777_7777, 4'hF, 1, 1'b0, 1'b1, 32'h0000_0000},
            '{1'b1, 1'b0, 32'h0000_0010, 32'h0,         4'hF, 3, 1'b1, 1'b0, 32'hDEAD_BEEF},
            '{1'b0, 1'b1, 32'h0000_0FFC, 32'hCAFE_F00D, 4'hF, 3, 1'b0, 1'b0, 32'hDEAD_BEEF},
            '{1'b1, 1'b0, 32'h0000_0FFC, 32'h0,         4'hF, 3, 1'b1, 1'b0, 32'hCAFE_F00D},
            '{1'b1, 1'b0, 32'h0000_7FFC, 32'h0,         4'hF, 3, 1'b1, 1'b0, 32'hCAFE_F00D}
        };

        foreach (vecs[i]) begin
            access(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, vecs[i].s, n, v, e, q, early);
            check($sformatf("v%0d_stall_cycles", i), n, vecs[i].exp_stall);
            check($sformatf("v%0d_valid", i), {31'b0, v}, {31'b0, vecs[i].exp_valid});
            check($sformatf("v%0d_err", i), {31'b0, e}, {31'b0, vecs[i].exp_err});
            check($sformatf("v%0d_rdata", i), q, vecs[i].exp_rdata);
            check($sformatf("v%0d_no_early_flag", i), {31'b0, early}, 32'd0);
        end

        // Changing or dropping the request during BUSY must not alter the latched store.
        access(1'b0, 1'b1, 32'h34, 32'h6666_6666, 4'hF, n, v, e, q, early);
        @(negedge clk);
        mem_wr = 1'b1; addr = 32'h30; wdata = 32'h5555_5555;
        #1;
        n = 0;
        if (stall) n++;
        @(negedge clk);
        addr = 32'h34; wdata = 32'h0; mem_wr = 1'b0;
        #1;
        while (stall && n < 20) begin
            n++;
            @(negedge clk);
            #1;
        end
        check("busy_ignore_stall_cycles", n, 32'd3);
        access(1'b1, 1'b0, 32'h30, 32'h0, 4'hF, n, v, e, q, early);
        check("busy_ignore_rd30", q, 32'h5555_5555);
        access(1'b1, 1'b0, 32'h34, 32'h0, 4'hF, n, v, e, q, early);
        check("busy_ignore_rd34", q, 32'h6666_6666);

        // Request held continuously: DONE cycle drops stall, next access starts with no overlap.
        @(negedge clk);
        mem_rd = 1'b1; addr = 32'h10;
        for (int i = 0; i < 8; i++) begin
            #1;
            pat_stall[7-i] = stall;
            pat_valid[7-i] = rdata_valid;
            if (i < 7) @(negedge clk);
        end
        mem_rd = 1'b0;
        check("b2b_stall_pattern", {24'b0, pat_stall}, 32'h0000_00EE);
        check("b2b_valid_pattern", {24'b0, pat_valid}, 32'h0000_0011);

        // Reset in the second BUSY cycle aborts the store.
        @(negedge clk);
        mem_wr = 1'b1; addr = 32'h10; wdata = 32'h9999_9999;
        @(negedge clk);
        @(negedge clk);
        #1;
        check("pre_reset_stall", {31'b0, stall}, 32'd1);
        rst = 1'b0;
        #1;
        check("midreset_stall", {31'b0, stall}, 32'd0);
        check("midreset_rdata", rdata, 32'd0);
        check("midreset_flags", {30'b0, rdata_valid, misalign_err}, 32'd0);
        mem_wr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        access(1'b1, 1'b0, 32'h10, 32'h0, 4'hF, n, v, e, q, early);
        check("post_reset_rd10", q, 32'hDEAD_BEEF);
        check("post_reset_valid", {31'b0, v}, 32'd1);

`ifdef DMEM_BYTE_STROBE_EN
        access(1'b0, 1'b1, 32'h40, 32'hAABB_CCDD, 4'hF, n, v, e, q, early);
        access(1'b0, 1'b1, 32'h40, 32'h1122_3344, 4'b0101, n, v, e, q, early);
        access(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, n, v, e, q, early);
        check("strobe_partial", q, 32'hAA22_CC44);
        access(1'b0, 1'b1, 32'h40, 32'h0000_0000, 4'b0000, n, v, e, q, early);
        check("strobe_zero_err", {31'b0, e}, 32'd0);
        access(1'b1, 1'b0, 32'h40, 32'h0, 4'hF, n, v, e, q, early);
        check("strobe_zero_noop", q, 32'hAA22_CC44);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
